z80_sound_comm: RTL and testbench
=================================

Z80_SOUND_COMM -- requirements
Module: z80_sound_comm

Interface
REQ-001 SHALL have ports, one per line: name  direction  width  meaning.
- CLK  in  1  single system clock; all state on its rising edge.
- nRESET  in  1  asynchronous active-low reset.
- SDA  in  16  Z80 address bus.
- SDD_OUT  in  8  Z80 write data.
- nIORQ, nRD, nWR  in  1 each  Z80 strobes, active-low.
- IO_DOUT  out  8  read data for Z80 I/O reads.
- IO_DOUT_EN  out  1  high while a decoded Z80 I/O read targets this block.
- nNMI  out  1  Z80 NMI request, active-low.
- CMD_WR  in  1  one-CLK strobe: 68k writes sound command.
- CMD_DIN  in  8  68k sound command byte.
- REPLY  out  8  last Z80 reply byte, to 68k.
- BANK0..BANK3  out  8 each  ZMC window bank numbers.

Function
REQ-002 SHALL detect each Z80 I/O read (nIORQ=0 and nRD=0) and I/O write (nIORQ=0 and nWR=0) as a single one-CLK event on the first CLK where the condition holds after it was false.
REQ-003 SHALL act on an event in the CLK after detection; repeated CLKs within one access SHALL produce no further events.
REQ-004 SHALL ignore I/O cycles with neither nRD nor nWR low (interrupt acknowledge).
REQ-005 Read decode on SDA[3:0]: 0x0 returns CMD; 0x8..0xB latch SDA[15:8] into BANK0..BANK3 respectively and return 0x00; other values leave IO_DOUT_EN low.
REQ-006 IO_DOUT and IO_DOUT_EN SHALL be combinational from decode and register state while the read is active, with zero added latency.
REQ-007 Write decode on SDA[4:0]: 0x08 sets NMI_EN=1; 0x18 sets NMI_EN=0; 0x0C loads SDD_OUT into REPLY; all other writes are ignored.
REQ-008 CMD_WR SHALL load CMD from CMD_DIN and set PENDING=1 only when NMI_EN=1; CMD SHALL load regardless of NMI_EN.
REQ-009 A Z80 read event of port 0x0 SHALL clear PENDING.
REQ-010 nNMI SHALL equal NOT(PENDING AND NMI_EN), registered, and SHALL hold low until cleared.
REQ-011 Simultaneous CMD_WR and port-0x0 read event: set wins; PENDING stays 1 and CMD takes the new byte.
REQ-012 Simultaneous CMD_WR and write to 0x18: disable takes effect; PENDING is set only if NMI_EN was 1 before the edge; nNMI deasserts next CLK.
REQ-013 Re-enabling NMI (write 0x08) with PENDING=1 SHALL reassert nNMI next CLK.
REQ-014 Back-to-back CMD_WR strobes SHALL overwrite CMD with the last byte; only one NMI assertion results.

Reset
REQ-015 While nRESET=0: CMD=0x00, REPLY=0x00, NMI_EN=0, PENDING=0, nNMI=1, IO_DOUT_EN=0, BANK0=0x1E, BANK1=0x0E, BANK2=0x06, BANK3=0x02, edge-detect history=inactive.
REQ-016 Reset asserted mid-access SHALL abort the access; after release an access already in progress SHALL NOT generate an event.

Structure
REQ-017 A shared package SHALL hold port constants (0x0, 0x8..0xB, 0x08, 0x18, 0x0C) and the four bank reset values.
REQ-018 The access edge detector SHALL be one sub-module, z80_io_strobe, emitting rd_evt and wr_evt.

Verification
REQ-019 Reset, then CMD_WR with 0x5A and NMI_EN=0 -> CMD=0x5A, nNMI stays 1; Z80 read of port 0x00 -> IO_DOUT=0x5A, IO_DOUT_EN=1.
REQ-020 Write 0x08, then CMD_WR 0x13 -> nNMI low within 2 CLK; read of port 0x00 -> 0x13 returned, nNMI high next CLK.
REQ-021 Read of port 0x09 with SDA=0x2109 held for 8 CLK -> BANK1=0x21 after one event; other banks unchanged.
REQ-022 Write 0x0C with SDD_OUT=0xA7 -> REPLY=0xA7; write 0x18 with PENDING=1 -> nNMI high; write 0x08 -> nNMI low again.
REQ-023 CMD_WR 0x44 in the same CLK as a port-0x00 read event, NMI_EN=1 -> PENDING=1, CMD=0x44, nNMI low.
REQ-024 nRESET low during an active port-0x0A read, released while the read is still active -> BANK2=0x06, no event, all outputs at reset values.

Source files
------------

// File: rtl/z80_sound_comm_pkg.sv
// z80_sound_comm_pkg: Z80 port map, bank reset values and strobe states
package z80_sound_comm_pkg;
  localparam logic [3:0] RD_CMD = 4'h0;
  localparam logic [3:0] RD_BANK0 = 4'h8;
  localparam logic [3:0] RD_BANK1 = 4'h9;
  localparam logic [3:0] RD_BANK2 = 4'hA;
  localparam logic [3:0] RD_BANK3 = 4'hB;
  localparam logic [4:0] WR_NMI_EN = 5'h08;
  localparam logic [4:0] WR_NMI_DIS = 5'h18;
  localparam logic [4:0] WR_REPLY = 5'h0C;
  localparam logic [7:0] BANK0_RST = 8'h1E;
  localparam logic [7:0] BANK1_RST = 8'h0E;
  localparam logic [7:0] BANK2_RST = 8'h06;
  localparam logic [7:0] BANK3_RST = 8'h02;
  typedef enum logic [1:0] {ST_BLOCKED, ST_IDLE, ST_BUSY} strobe_st_e;
  function automatic logic is_bank(input logic [3:0] p);
    return p >= RD_BANK0 && p <= RD_BANK3;
  endfunction
endpackage

// File: rtl/z80_sound_comm_if.sv
// z80_sound_comm_if: Z80 side I/O bus of the sound communication block
interface z80_sound_comm_if;
  logic [15:0] SDA;
  logic [7:0] SDD_OUT;
  logic nIORQ;
  logic nRD;
  logic nWR;
  logic [7:0] IO_DOUT;
  logic IO_DOUT_EN;
  logic nNMI;
  modport master (output SDA, SDD_OUT, nIORQ, nRD, nWR, input IO_DOUT, IO_DOUT_EN, nNMI);
  modport slave (input SDA, SDD_OUT, nIORQ, nRD, nWR, output IO_DOUT, IO_DOUT_EN, nNMI);
endinterface

// File: rtl/z80_sound_comm_strobe.sv
// z80_io_strobe: one registered event per Z80 I/O access; an access already
// in progress when reset releases is ignored until the bus goes idle
module z80_io_strobe
  import z80_sound_comm_pkg::*;
(
  input  logic CLK,
  input  logic nRESET,
  input  logic nIORQ,
  input  logic nRD,
  input  logic nWR,
  output logic rd_evt,
  output logic wr_evt,
  output logic rd_act
);
  strobe_st_e st_q, st_d;
  logic rd_evt_q, rd_evt_d, wr_evt_q, wr_evt_d, rd_c, wr_c;
  always_comb begin
    rd_c = !nIORQ && !nRD;
    wr_c = !nIORQ && !nWR;
    st_d = !(rd_c || wr_c) ? ST_IDLE : (st_q == ST_IDLE ? ST_BUSY : st_q);
    rd_evt_d = st_q == ST_IDLE && rd_c;
    wr_evt_d = st_q == ST_IDLE && wr_c;
  end
  always_ff @(posedge CLK or negedge nRESET)
    if (!nRESET) begin
      st_q <= ST_BLOCKED;
      rd_evt_q <= 1'b0;
      wr_evt_q <= 1'b0;
    end else begin
      st_q <= st_d;
      rd_evt_q <= rd_evt_d;
      wr_evt_q <= wr_evt_d;
    end
  assign rd_evt = rd_evt_q;
  assign wr_evt = wr_evt_q;
  assign rd_act = rd_c && st_q != ST_BLOCKED;
endmodule

// File: rtl/z80_sound_comm.sv
// z80_sound_comm: 68k->Z80 sound command mailbox with NMI, Z80 reply byte
// and ZMC bank registers latched from Z80 I/O reads
module z80_sound_comm
  import z80_sound_comm_pkg::*;
(
  input  logic CLK,
  input  logic nRESET,
  z80_sound_comm_if.slave z80,
  input  logic CMD_WR,
  input  logic [7:0] CMD_DIN,
  output logic [7:0] REPLY,
  output logic [7:0] BANK0,
  output logic [7:0] BANK1,
  output logic [7:0] BANK2,
  output logic [7:0] BANK3
);
  logic rd_evt, wr_evt, rd_act;
  logic [7:0] cmd_q, cmd_d, reply_q, reply_d;
  logic [3:0][7:0] bank_q, bank_d;
  logic nmi_en_q, nmi_en_d, pending_q, pending_d, nnmi_q, nnmi_d;
  logic [3:0] rd_port;
  logic [4:0] wr_port;
  z80_io_strobe u_strobe (
    .CLK(CLK),
    .nRESET(nRESET),
    .nIORQ(z80.nIORQ),
    .nRD(z80.nRD),
    .nWR(z80.nWR),
    .rd_evt(rd_evt),
    .wr_evt(wr_evt),
    .rd_act(rd_act)
  );
  always_comb begin
    rd_port = z80.SDA[3:0];
    wr_port = z80.SDA[4:0];
    cmd_d = CMD_WR ? CMD_DIN : cmd_q;
    reply_d = (wr_evt && wr_port == WR_REPLY) ? z80.SDD_OUT : reply_q;
    nmi_en_d = (wr_evt && wr_port == WR_NMI_EN) ? 1'b1 :
               (wr_evt && wr_port == WR_NMI_DIS) ? 1'b0 : nmi_en_q;
    // a new command beats the Z80 acknowledge; arming uses the pre-edge enable
    pending_d = (CMD_WR && nmi_en_q) ? 1'b1 :
                (rd_evt && rd_port == RD_CMD) ? 1'b0 : pending_q;
    nnmi_d = !(pending_d && nmi_en_d);
    bank_d = bank_q;
    if (rd_evt && is_bank(rd_port)) bank_d[rd_port[1:0]] = z80.SDA[15:8];
  end
  always_ff @(posedge CLK or negedge nRESET)
    if (!nRESET) begin
      cmd_q <= 8'h00;
      reply_q <= 8'h00;
      nmi_en_q <= 1'b0;
      pending_q <= 1'b0;
      nnmi_q <= 1'b1;
      bank_q <= {BANK3_RST, BANK2_RST, BANK1_RST, BANK0_RST};
    end else begin
      cmd_q <= cmd_d;
      reply_q <= reply_d;
      nmi_en_q <= nmi_en_d;
      pending_q <= pending_d;
      nnmi_q <= nnmi_d;
      bank_q <= bank_d;
    end
  assign z80.IO_DOUT_EN = rd_act && (rd_port == RD_CMD || is_bank(rd_port));
  assign z80.IO_DOUT = (z80.IO_DOUT_EN && rd_port == RD_CMD) ? cmd_q : 8'h00;
  assign z80.nNMI = nnmi_q;
  assign REPLY = reply_q;
  assign BANK0 = bank_q[0];
  assign BANK1 = bank_q[1];
  assign BANK2 = bank_q[2];
  assign BANK3 = bank_q[3];
endmodule

// File: tb/tb_z80_sound_comm.sv
// tb_z80_sound_comm: directed and randomized Z80/68k traffic checked against
// a transaction-level model of the mailbox, NMI and bank registers
module tb_z80_sound_comm;
  logic CLK = 1'b0;
  logic nRESET = 1'b1;
  logic CMD_WR = 1'b0;
  logic [7:0] CMD_DIN = 8'h00;
  logic [7:0] REPLY, BANK0, BANK1, BANK2, BANK3;
  logic [40:0] obs;
  int n_tests = 0;
  int n_fail = 0;
  logic [7:0] m_cmd, m_reply;
  logic [7:0] m_bank [4];
  bit m_en, m_pend;

  z80_sound_comm_if bus ();
  z80_sound_comm dut (
    .CLK(CLK), .nRESET(nRESET), .z80(bus), .CMD_WR(CMD_WR), .CMD_DIN(CMD_DIN),
    .REPLY(REPLY), .BANK0(BANK0), .BANK1(BANK1), .BANK2(BANK2), .BANK3(BANK3)
  );

  always #5 CLK = ~CLK;
  assign obs = {REPLY, BANK3, BANK2, BANK1, BANK0, bus.nNMI};

  function automatic void m_reset();
    m_cmd = 8'h00; m_reply = 8'h00; m_en = 0; m_pend = 0;
    m_bank[0] = 8'h1E; m_bank[1] = 8'h0E; m_bank[2] = 8'h06; m_bank[3] = 8'h02;
  endfunction
  function automatic void m_cmd_wr(input logic [7:0] b);
    m_cmd = b;
    if (m_en) m_pend = 1;
  endfunction
  function automatic void m_rd_evt(input logic [15:0] a);
    if (a[3:0] == 4'h0) m_pend = 0;
    else if (a[3:0] >= 4'h8 && a[3:0] <= 4'hB) m_bank[a[3:0] - 4'h8] = a[15:8];
  endfunction
  function automatic void m_wr_evt(input logic [15:0] a, input logic [7:0] d);
    if (a[4:0] == 5'h08) m_en = 1;
    else if (a[4:0] == 5'h18) m_en = 0;
    else if (a[4:0] == 5'h0C) m_reply = d;
  endfunction
  function automatic logic [40:0] m_vec();
    return {m_reply, m_bank[3], m_bank[2], m_bank[1], m_bank[0], !(m_pend && m_en)};
  endfunction

  task automatic cmd_pulse(input logic [7:0] b);
    @(negedge CLK); CMD_WR = 1'b1; CMD_DIN = b;
    @(negedge CLK); CMD_WR = 1'b0;
    m_cmd_wr(b);
  endtask

  // one Z80 I/O access held for hold CLKs; optional CMD_WR on negedge cmd_at (1 = same edge as the action)
  task automatic z80_io(input bit wr, input logic [15:0] a, input logic [7:0] d, input int hold,
                        input int cmd_at, input logic [7:0] cb, output logic en, output logic [7:0] dout,
                        output logic exp_en, output logic [7:0] exp_d);
    exp_en = !wr && (a[3:0] == 4'h0 || (a[3:0] >= 4'h8 && a[3:0] <= 4'hB));
    exp_d = (a[3:0] == 4'h0) ? m_cmd : 8'h00;
    @(negedge CLK);
    bus.SDA = a; bus.SDD_OUT = d; bus.nIORQ = 1'b0;
    if (wr) bus.nWR = 1'b0; else bus.nRD = 1'b0;
    #1 en = bus.IO_DOUT_EN; dout = bus.IO_DOUT;
    for (int i = 1; i <= hold; i++) begin
      @(negedge CLK); CMD_WR = (i == cmd_at); CMD_DIN = cb;
    end
    @(negedge CLK);
    CMD_WR = 1'b0; bus.nIORQ = 1'b1; bus.nRD = 1'b1; bus.nWR = 1'b1;
    repeat (2) @(negedge CLK);
    if (wr && cmd_at == 1) begin
      m_cmd_wr(cb); m_wr_evt(a, d);
    end else begin
      if (wr) m_wr_evt(a, d); else m_rd_evt(a);
      if (cmd_at >= 1 && cmd_at <= hold) m_cmd_wr(cb);
    end
  endtask

  task automatic test_reset();
    logic en, ee; logic [7:0] dd, ed;
    #2 nRESET = 1'b0; m_reset();
    repeat (3) @(negedge CLK);
    n_tests++;
    if (obs !== m_vec() || bus.IO_DOUT_EN !== 1'b0) begin
      n_fail++; $display("FAIL reset_state got %h/%b want %h/0", obs, bus.IO_DOUT_EN, m_vec());
    end
    nRESET = 1'b1;
    z80_io(0, 16'h0000, 8'h00, 2, 0, 8'h00, en, dd, ee, ed);
    n_tests++;
    if (en !== 1'b1 || dd !== 8'h00) begin
      n_fail++; $display("FAIL reset_cmd got %b/%h want 1/00", en, dd);
    end
  endtask

  task automatic test_cmd_no_nmi();
    logic en, ee; logic [7:0] dd, ed;
    cmd_pulse(8'h5A);
    repeat (2) @(negedge CLK);
    n_tests++;
    if (bus.nNMI !== 1'b1 || obs !== m_vec()) begin
      n_fail++; $display("FAIL cmd_no_nmi got %h want %h", obs, m_vec());
    end
    z80_io(0, 16'h4400, 8'h00, 2, 0, 8'h00, en, dd, ee, ed);
    n_tests++;
    if (en !== 1'b1 || dd !== 8'h5A) begin
      n_fail++; $display("FAIL cmd_read got %b/%h want 1/5a", en, dd);
    end
  endtask

  task automatic test_nmi();
    logic en, ee; logic [7:0] dd, ed;
    z80_io(1, 16'h0008, 8'h00, 2, 0, 8'h00, en, dd, ee, ed);
    cmd_pulse(8'h13);
    n_tests++;
    if (bus.nNMI !== 1'b0) begin
      n_fail++; $display("FAIL nmi_assert got %b want 0", bus.nNMI);
    end
    z80_io(0, 16'h0000, 8'h00, 2, 0, 8'h00, en, dd, ee, ed);
    n_tests++;
    if (en !== ee || dd !== 8'h13 || obs !== m_vec() || bus.nNMI !== 1'b1) begin
      n_fail++; $display("FAIL nmi_ack got %b/%h %h want 1/13 %h", en, dd, obs, m_vec());
    end
  endtask

  task automatic test_bank_hold();
    logic en, ee; logic [7:0] dd, ed;
    z80_io(0, 16'h2109, 8'h00, 8, 0, 8'h00, en, dd, ee, ed);
    n_tests++;
    if (en !== 1'b1 || dd !== 8'h00 || obs !== m_vec() || BANK1 !== 8'h21) begin
      n_fail++; $display("FAIL bank_hold got %b/%h %h want 1/00 %h", en, dd, obs, m_vec());
    end
    cmd_pulse(8'h77);
    z80_io(0, 16'hAB00, 8'h00, 8, 5, 8'h88, en, dd, ee, ed);
    n_tests++;
    if (dd !== 8'h77 || obs !== m_vec() || bus.nNMI !== 1'b0) begin
      n_fail++; $display("FAIL single_event got %h %h want 77 %h", dd, obs, m_vec());
    end
  endtask

  task automatic test_reply_mask();
    logic en, ee; logic [7:0] dd, ed;
    z80_io(1, 16'h000C, 8'hA7, 2, 0, 8'h00, en, dd, ee, ed);
    n_tests++;
    if (REPLY !== 8'hA7 || obs !== m_vec()) begin
      n_fail++; $display("FAIL reply got %h want a7", REPLY);
    end
    z80_io(1, 16'h0018, 8'h00, 2, 0, 8'h00, en, dd, ee, ed);
    n_tests++;
    if (bus.nNMI !== 1'b1 || obs !== m_vec()) begin
      n_fail++; $display("FAIL nmi_disable got %b want 1", bus.nNMI);
    end
    z80_io(1, 16'h0008, 8'h00, 2, 0, 8'h00, en, dd, ee, ed);
    n_tests++;
    if (bus.nNMI !== 1'b0 || obs !== m_vec()) begin
      n_fail++; $display("FAIL nmi_reenable got %b want 0", bus.nNMI);
    end
  endtask

  task automatic test_simultaneous();
    logic en, ee; logic [7:0] dd, ed;
    z80_io(0, 16'h0000, 8'h00, 3, 1, 8'h44, en, dd, ee, ed);
    n_tests++;
    if (bus.nNMI !== 1'b0 || obs !== m_vec()) begin
      n_fail++; $display("FAIL set_wins got %h want %h", obs, m_vec());
    end
    z80_io(0, 16'h0000, 8'h00, 2, 0, 8'h00, en, dd, ee, ed);
    n_tests++;
    if (dd !== 8'h44 || bus.nNMI !== 1'b1) begin
      n_fail++; $display("FAIL set_wins_cmd got %h/%b want 44/1", dd, bus.nNMI);
    end
    z80_io(1, 16'h0018, 8'h00, 2, 1, 8'h91, en, dd, ee, ed);
    z80_io(1, 16'h0008, 8'h00, 2, 0, 8'h00, en, dd, ee, ed);
    n_tests++;
    if (bus.nNMI !== 1'b0 || obs !== m_vec()) begin
      n_fail++; $display("FAIL disable_race_en got %h want %h", obs, m_vec());
    end
    z80_io(0, 16'h0000, 8'h00, 2, 0, 8'h00, en, dd, ee, ed);
    z80_io(1, 16'h0018, 8'h00, 2, 0, 8'h00, en, dd, ee, ed);
    z80_io(1, 16'h0018, 8'h00, 2, 1, 8'h92, en, dd, ee, ed);
    z80_io(1, 16'h0008, 8'h00, 2, 0, 8'h00, en, dd, ee, ed);
    n_tests++;
    if (bus.nNMI !== 1'b1 || obs !== m_vec()) begin
      n_fail++; $display("FAIL disable_race_dis got %h want %h", obs, m_vec());
    end
  endtask

  task automatic test_iack();
    cmd_pulse(8'h3C);
    @(negedge CLK); bus.SDA = 16'h0000; bus.nIORQ = 1'b0;
    repeat (4) @(negedge CLK);
    n_tests++;
    if (bus.IO_DOUT_EN !== 1'b0 || obs !== m_vec() || bus.nNMI !== 1'b0) begin
      n_fail++; $display("FAIL iack got %b %h want 0 %h", bus.IO_DOUT_EN, obs, m_vec());
    end
    bus.nIORQ = 1'b1;
    repeat (2) @(negedge CLK);
  endtask

  task automatic test_random();
    logic en, ee; logic [7:0] dd, ed;
    logic [4:0] lo;
    int op, hold, ca, k;
    for (int n = 0; n < 200; n++) begin
      op = $urandom_range(0, 2);
      hold = $urandom_range(1, 4);
      ca = $urandom_range(0, hold);
      if (op == 0) begin
        cmd_pulse(8'($urandom));
        ee = 1'b0; en = 1'b0; dd = 8'h00; ed = 8'h00;
      end else if (op == 1) begin
        z80_io(0, 16'($urandom), 8'($urandom), hold, ca, 8'($urandom), en, dd, ee, ed);
      end else begin
        k = $urandom_range(0, 3);
        lo = (k == 0) ? 5'h08 : (k == 1) ? 5'h18 : (k == 2) ? 5'h0C : 5'($urandom);
        z80_io(1, {11'($urandom), lo}, 8'($urandom), hold, ca, 8'($urandom), en, dd, ee, ed);
      end
      n_tests++;
      if (obs !== m_vec() || en !== ee || (ee && dd !== ed)) begin
        n_fail++;
        $display("FAIL random_%0d op %0d got %h %b/%h want %h %b/%h", n, op, obs, en, dd, m_vec(), ee, ed);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic en, ee; logic [7:0] dd, ed;
    @(negedge CLK); bus.SDA = 16'h320A; bus.nIORQ = 1'b0; bus.nRD = 1'b0;
    @(negedge CLK); nRESET = 1'b0; m_reset();
    #1;
    n_tests++;
    if (bus.IO_DOUT_EN !== 1'b0 || obs !== m_vec()) begin
      n_fail++; $display("FAIL reset_mid_hold got %b %h want 0 %h", bus.IO_DOUT_EN, obs, m_vec());
    end
    repeat (2) @(negedge CLK); nRESET = 1'b1;
    repeat (4) @(negedge CLK);
    n_tests++;
    if (bus.IO_DOUT_EN !== 1'b0 || obs !== m_vec() || BANK2 !== 8'h06) begin
      n_fail++; $display("FAIL reset_mid_release got %b %h want 0 %h", bus.IO_DOUT_EN, obs, m_vec());
    end
    bus.nIORQ = 1'b1; bus.nRD = 1'b1;
    repeat (2) @(negedge CLK);
    n_tests++;
    if (obs !== m_vec()) begin
      n_fail++; $display("FAIL reset_mid_after got %h want %h", obs, m_vec());
    end
    z80_io(0, 16'h550A, 8'h00, 2, 0, 8'h00, en, dd, ee, ed);
    n_tests++;
    if (en !== 1'b1 || BANK2 !== 8'h55 || obs !== m_vec()) begin
      n_fail++; $display("FAIL reset_mid_rearm got %b %h want 1 %h", en, obs, m_vec());
    end
  endtask

  initial begin
    bus.SDA = 16'h0000; bus.SDD_OUT = 8'h00; bus.nIORQ = 1'b1; bus.nRD = 1'b1; bus.nWR = 1'b1;
    test_reset();
    test_cmd_no_nmi();
    test_nmi();
    test_bank_hold();
    test_reply_mask();
    test_simultaneous();
    test_iack();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
